// File: rtl/rgb444_pixel_capture.sv
// RGB444 camera byte-stream capture: two bytes -> one 12-bit pixel with x/y tags.
// Optional CAPTURE_FRAME_SKIP_EN captures every other frame.
module rgb444_pixel_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int X_W      = 10,
  parameter int Y_W      = 9
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           vsync,
  input  logic           href,
  input  logic [7:0]     d,
  output logic [11:0]    pixel_data,
  output logic           pixel_valid,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           frame_start,
  output logic           frame_done,
  output logic           line_err
);

  localparam logic [X_W-1:0] H_MAX = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0] V_MAX = Y_W'(V_ACTIVE);

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    FRAME     = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic           vs_q, hr_q, vs_p, hr_p;
  logic [7:0]     d_q;
  logic           phase_q;
  logic [3:0]     r_q;
  logic [X_W-1:0] xc_q;
  logic [Y_W-1:0] yc_q;

  logic vs_fall, vs_rise, hr_fall, take;
  logic start_c, end_c, line_c, byte_c;
  logic emit_c, ovf_c, err_c;

  assign vs_fall = vs_p & ~vs_q;
  assign vs_rise = ~vs_p & vs_q;
  assign hr_fall = hr_p & ~hr_q;

`ifdef CAPTURE_FRAME_SKIP_EN
  logic tog_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tog_q <= 1'b0;
    else if (vs_fall) tog_q <= ~tog_q;
  end

  // Frame is taken when the flipped toggle reads 1.
  assign take = ~tog_q;
`else
  assign take = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_q <= 1'b0;
      hr_q <= 1'b0;
      d_q  <= '0;
      vs_p <= 1'b0;
      hr_p <= 1'b0;
    end else begin
      vs_q <= vsync;
      hr_q <= href;
      d_q  <= d;
      vs_p <= vs_q;
      hr_p <= hr_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= WAIT_SYNC;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_SYNC: if (vs_fall && take) state_d = FRAME;
      FRAME:     if (vs_rise) state_d = WAIT_SYNC;
      default:   state_d = WAIT_SYNC;
    endcase
  end

  always_comb begin
    start_c = 1'b0;
    end_c   = 1'b0;
    line_c  = 1'b0;
    byte_c  = 1'b0;
    case (state_q)
      WAIT_SYNC: start_c = vs_fall & take;
      FRAME: begin
        end_c  = vs_rise;
        line_c = hr_fall;
        byte_c = hr_q & ~vs_rise;
      end
      default: ;
    endcase
    emit_c = byte_c & phase_q & (xc_q < H_MAX) & (yc_q < V_MAX);
    ovf_c  = byte_c & phase_q & (xc_q >= H_MAX);
    err_c  = (line_c & phase_q) | ovf_c | (end_c & hr_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q     <= 1'b0;
      r_q         <= '0;
      xc_q        <= '0;
      yc_q        <= '0;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;
    end else begin
      pixel_valid <= emit_c;
      frame_start <= start_c;
      frame_done  <= end_c;

      if (start_c) line_err <= 1'b0;
      else if (err_c) line_err <= 1'b1;

      if (byte_c) phase_q <= ~phase_q;
      else phase_q <= 1'b0;

      if (byte_c && !phase_q) r_q <= d_q[3:0];

      if (emit_c) begin
        pixel_data <= {r_q, d_q};
        x          <= xc_q;
        y          <= yc_q;
        xc_q       <= xc_q + 1'b1;
      end

      if (start_c) begin
        xc_q <= '0;
        yc_q <= '0;
      end else if (line_c && xc_q != '0) begin
        xc_q <= '0;
        if (yc_q != V_MAX) yc_q <= yc_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rgb444_pixel_capture.sv
// Random/directed byte streams checked against a frame/line level reference model.
// Model follows CAPTURE_FRAME_SKIP_EN when the macro is defined.
module tb_rgb444_pixel_capture;

  localparam int H = 640;
  localparam int V = 480;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vsync, href;
  logic [7:0]  d;
  logic [11:0] pixel_data;
  logic        pixel_valid;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        frame_start, frame_done, line_err;

  rgb444_pixel_capture dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .vsync      (vsync),
    .href       (href),
    .d          (d),
    .pixel_data (pixel_data),
    .pixel_valid(pixel_valid),
    .x          (x),
    .y          (y),
    .frame_start(frame_start),
    .frame_done (frame_done),
    .line_err   (line_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         v;
    bit         h;
    logic [7:0] d;
  } stim_t;

  typedef struct {
    bit          val;
    logic [11:0] pd;
    int          px;
    int          py;
    bit          fs;
    bit          fd;
    bit          err;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];

  int total = 0;
  int bad   = 0;
  int n_pix = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic push(input bit v, input bit h, input logic [7:0] b);
    stim_t s;
    s.v = v;
    s.h = h;
    s.d = b;
    stim_q.push_back(s);
  endtask

  task automatic idle(input bit v, input int n);
    for (int i = 0; i < n; i++) push(v, 1'b0, 8'($urandom));
  endtask

  task automatic line_rand(input int len, input int gap);
    for (int i = 0; i < len; i++) push(1'b0, 1'b1, 8'($urandom));
    idle(1'b0, gap);
  endtask

  task automatic vs_pulse();
    idle(1'b1, 3);
    idle(1'b0, 2);
  endtask

  // Frame/line semantics: pairs of bytes in a href run make pixels.
  function automatic void run_model();
    bit pv = 0, ph = 0, inf = 0, tog = 0, take;
    bit err = 0;
    int nb = 0, mx = 0, my = 0;
    logic [3:0]  r = 0;
    logic [11:0] last = 0;
    foreach (stim_q[k]) begin
      exp_t e;
      bit v, h, vf, vr, hf;
      v  = stim_q[k].v;
      h  = stim_q[k].h;
      vf = pv && !v;
      vr = !pv && v;
      hf = ph && !h;
      e.val = 0; e.fs = 0; e.fd = 0; e.px = 0; e.py = 0;
      if (vf) begin
        tog = !tog;
`ifdef CAPTURE_FRAME_SKIP_EN
        take = tog;
`else
        take = 1;
`endif
      end else begin
        take = 0;
      end
      if (!inf) begin
        if (vf && take) begin
          inf = 1; e.fs = 1; err = 0;
          mx = 0; my = 0; nb = 0;
        end
      end else begin
        if (hf) begin
          if (nb % 2 == 1) err = 1;
          if (mx > 0) begin
            mx = 0;
            if (my < V) my++;
          end
        end
        if (vr) begin
          e.fd = 1;
          if (h) err = 1;
          inf = 0;
          nb = 0;
        end else if (h) begin
          nb++;
          if (nb % 2 == 1) r = stim_q[k].d[3:0];
          else if (mx < H && my < V) begin
            last = {r, stim_q[k].d};
            e.val = 1; e.px = mx; e.py = my;
            mx++;
          end else if (mx >= H) err = 1;
        end
        if (!h) nb = 0;
      end
      e.pd = last;
      e.err = err;
      exp_q.push_back(e);
      pv = v;
      ph = h;
    end
  endfunction

  initial begin
    exp_t e;
    int n;
    stim_t s;

    // Capture starts mid-line with vsync low: nothing until a vsync fall.
    for (int i = 0; i < 7; i++) push(1'b0, 1'b1, 8'($urandom));
    idle(1'b0, 2);
    vs_pulse();
    // Frame 1
    push(0, 1, 8'h0A); push(0, 1, 8'h5C); push(0, 1, 8'h03); push(0, 1, 8'hF1);
    idle(1'b0, 3);
    push(0, 1, 8'h0F); push(0, 1, 8'hFF); push(0, 1, 8'h07);
    idle(1'b0, 3);
    line_rand(2 * (H + 2), 3);
    for (int i = 0; i < 6; i++) line_rand($urandom_range(0, 20), $urandom_range(1, 4));
    push(0, 1, 8'h3C);
    push(1, 1, 8'hC3);
    idle(1'b1, 3);
    idle(1'b0, 2);
    // Frame 2: ends with href fall and vsync rise together
    for (int i = 0; i < 5; i++) line_rand($urandom_range(0, 16), $urandom_range(1, 3));
    for (int i = 0; i < 5; i++) push(0, 1, 8'($urandom));
    vs_pulse();
    // Frame 3: more lines than V_ACTIVE
    for (int i = 0; i < V + 5; i++) line_rand(2, 1);
    line_rand(6, 2);
    vs_pulse();
    // Frame 4
    for (int i = 0; i < 4; i++) line_rand($urandom_range(1, 12), $urandom_range(1, 3));
    idle(1'b1, 4);

    run_model();
    n = stim_q.size();

    reset_n = 1'b0;
    vsync = 1'b0;
    href  = 1'b0;
    d     = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(pixel_valid), 0);
    chk("rst_data", 32'(pixel_data), 0);
    chk("rst_x", 32'(x), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_fs", 32'(frame_start), 0);
    chk("rst_fd", 32'(frame_done), 0);
    chk("rst_err", 32'(line_err), 0);

    reset_n = 1'b1;
    s = stim_q[0];
    vsync = s.v; href = s.h; d = s.d;
    for (int m = 1; m < n + 2; m++) begin
      @(negedge clk);
      if (m >= 2) begin
        e = exp_q[m - 2];
        chk("valid", 32'(pixel_valid), 32'(e.val));
        chk("data", 32'(pixel_data), 32'(e.pd));
        if (e.val) begin
          n_pix++;
          chk("x", 32'(x), 32'(e.px));
          chk("y", 32'(y), 32'(e.py));
        end
        chk("frame_start", 32'(frame_start), 32'(e.fs));
        chk("frame_done", 32'(frame_done), 32'(e.fd));
        chk("line_err", 32'(line_err), 32'(e.err));
      end
      if (m < n) begin
        s = stim_q[m];
        vsync = s.v; href = s.h; d = s.d;
      end else begin
        vsync = 1'b1; href = 1'b0; d = 8'h00;
      end
    end
    chk("pixels_seen", 32'(n_pix > 0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
